// File: rtl/ibex_rvfi_trace_buf_if.sv
// ibex_rvfi_trace_buf_if: RVFI retirement feed and drain-side valid/ready read port.
interface ibex_rvfi_trace_buf_if;
  logic        rvfi_valid;
  logic [31:0] rvfi_pc;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic        rvfi_intr;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_insn;
  logic [1:0]  rd_flags;
  modport master (
    output rvfi_valid, rvfi_pc, rvfi_insn, rvfi_trap, rvfi_intr, rd_ready,
    input  rd_valid, rd_pc, rd_insn, rd_flags
  );
  modport slave (
    input  rvfi_valid, rvfi_pc, rvfi_insn, rvfi_trap, rvfi_intr, rd_ready,
    output rd_valid, rd_pc, rd_insn, rd_flags
  );
endinterface

// File: rtl/ibex_rvfi_trace_buf.sv
// ibex_rvfi_trace_buf: circular capture of retired instructions (wrap / fill / PC-trigger) with frozen drain port.
module ibex_rvfi_trace_buf #(
  parameter  int Depth = 16,
  localparam int CntW  = $clog2(Depth) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cfg_mode,
  input  logic [31:0]            cfg_trig_pc,
  input  logic [CntW-1:0]        cfg_post_cnt,
  input  logic                   arm,
  input  logic                   stop,
  ibex_rvfi_trace_buf_if.slave   bus,
  output logic [CntW-1:0]        count,
  output logic                   overflow,
  output logic                   triggered,
  output logic [1:0]             state
);
  localparam int AW = $clog2(Depth);
  localparam logic [1:0] OFF = 2'd0, FILL = 2'd2, TRIG = 2'd3;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;
  state_t st, st_nx;
  logic [1:0]      mode;
  logic [31:0]     trig_pc;
  logic [CntW-1:0] post_cfg, post_left;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     pc_mem [Depth];
  logic [31:0]     insn_mem [Depth];
  logic [1:0]      flag_mem [Depth];
  logic capturing, wr, full, ovw, hit, drop, pop;
  assign capturing = st == CAPTURE || st == POST;
  assign wr        = capturing && bus.rvfi_valid;
  assign full      = count == CntW'(Depth);
  assign ovw       = wr && full;
  assign hit       = wr && st == CAPTURE && mode == TRIG && bus.rvfi_pc == trig_pc;
  assign drop      = st == DONE && mode == FILL && bus.rvfi_valid;
  assign pop       = bus.rd_valid && bus.rd_ready;
  assign bus.rd_valid = st == DONE && count != '0;
  assign bus.rd_pc    = pc_mem[rd_ptr];
  assign bus.rd_insn  = insn_mem[rd_ptr];
  assign bus.rd_flags = flag_mem[rd_ptr];
  assign state        = st;
  always_comb begin
    st_nx = st;
    if (arm)
      st_nx = cfg_mode == OFF ? IDLE : CAPTURE;
    else if (capturing && stop)
      st_nx = DONE;
    else if (st == CAPTURE && mode == FILL && wr && count == CntW'(Depth - 1))
      st_nx = DONE;
    else if (hit)
      st_nx = post_cfg == '0 ? DONE : POST;
    else if (st == POST && wr && post_left == CntW'(1))
      st_nx = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      mode      <= OFF;
      trig_pc   <= '0;
      post_cfg  <= '0;
      post_left <= '0;
    end else begin
      st <= st_nx;
      if (arm) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        overflow  <= 1'b0;
        triggered <= 1'b0;
        mode      <= cfg_mode;
        trig_pc   <= cfg_trig_pc;
        // Clamp so the trigger entry can never be overwritten by its own post-capture
        post_cfg  <= cfg_post_cnt > CntW'(Depth - 1) ? CntW'(Depth - 1) : cfg_post_cnt;
        post_left <= '0;
      end else begin
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (ovw || pop) rd_ptr <= rd_ptr + 1'b1;
        if (wr && !full) count <= count + 1'b1;
        else if (pop) count <= count - 1'b1;
        if (ovw || drop) overflow <= 1'b1;
        if (hit) begin
          triggered <= 1'b1;
          post_left <= post_cfg;
        end else if (st == POST && wr) begin
          post_left <= post_left - 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !arm) begin
      pc_mem[wr_ptr]   <= bus.rvfi_pc;
      insn_mem[wr_ptr] <= bus.rvfi_insn;
      flag_mem[wr_ptr] <= {bus.rvfi_trap, bus.rvfi_intr};
    end
  end
endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// tb_ibex_rvfi_trace_buf: scenario tasks with a wrap-aware scoreboard of expected drained entries.
module tb_ibex_rvfi_trace_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_mode = '0;
  logic [31:0] cfg_trig_pc = '0;
  logic [4:0]  cfg_post_cnt = '0;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic [4:0]  count;
  logic        overflow, triggered;
  logic [1:0]  state;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {logic [31:0] pc; logic [31:0] insn; logic [1:0] fl;} ent_t;
  ent_t sb[$];
  ibex_rvfi_trace_buf_if bus ();
  ibex_rvfi_trace_buf #(.Depth(16)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_trig_pc(cfg_trig_pc),
    .cfg_post_cnt(cfg_post_cnt), .arm(arm), .stop(stop), .bus(bus),
    .count(count), .overflow(overflow), .triggered(triggered), .state(state)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_arm(input logic [1:0] m, input logic [31:0] tp, input logic [4:0] pc);
    cfg_mode = m; cfg_trig_pc = tp; cfg_post_cnt = pc; arm = 1'b1;
    tick();
    arm = 1'b0; cfg_mode = 2'd0; cfg_trig_pc = 32'hFFFF_FFFF; cfg_post_cnt = 5'd0;
    sb.delete();
  endtask
  task automatic retire(input logic [31:0] pc, input logic [1:0] fl, input bit keep);
    bus.rvfi_valid = 1'b1; bus.rvfi_pc = pc; bus.rvfi_insn = pc ^ 32'h5A5A_0013;
    bus.rvfi_trap = fl[1]; bus.rvfi_intr = fl[0];
    if (keep) begin
      sb.push_back('{pc, pc ^ 32'h5A5A_0013, fl});
      if (sb.size() > 16) sb.delete(0);
    end
    tick();
    bus.rvfi_valid = 1'b0;
  endtask
  task automatic drain(input string nm);
    ent_t e;
    bus.rd_ready = 1'b1;
    while (sb.size() > 0) begin
      if (bus.rd_valid !== 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL %s_valid: rd_valid=%0b with %0d entries still required", nm, bus.rd_valid, sb.size());
        sb.delete();
        break;
      end
      e = sb.pop_front();
      n_cmp++;
      if ({bus.rd_pc, bus.rd_insn, bus.rd_flags} !== {e.pc, e.insn, e.fl}) begin
        n_err++;
        $display("FAIL %s_pop: got pc=%h insn=%h fl=%b, required pc=%h insn=%h fl=%b",
                 nm, bus.rd_pc, bus.rd_insn, bus.rd_flags, e.pc, e.insn, e.fl);
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || count !== 5'd0 || state !== 2'd3) begin
      n_err++;
      $display("FAIL %s_drained: rd_valid=%0b count=%0d state=%0d, required 0/0/3", nm, bus.rd_valid, count, state);
    end
  endtask
  task automatic test_reset();
    n_cmp++;
    if ({state, count, overflow, triggered, bus.rd_valid} !== {2'd0, 5'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset: state=%0d count=%0d ovf=%0b trg=%0b rv=%0b, required all 0", state, count, overflow, triggered, bus.rd_valid);
    end
  endtask
  task automatic test_off();
    do_arm(2'd0, 32'h0, 5'd0);
    retire(32'h80, 2'b00, 0);
    n_cmp++;
    if (state !== 2'd0 || count !== 5'd0) begin
      n_err++; $display("FAIL off_mode: state=%0d count=%0d, required 0/0", state, count);
    end
  endtask
  task automatic test_fill();
    do_arm(2'd2, 32'h0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      retire(32'h100 + 4 * i, 2'(i), 1);
      if (i == 14) begin
        n_cmp++;
        if (state !== 2'd1 || count !== 5'd15) begin
          n_err++; $display("FAIL fill_15: state=%0d count=%0d, required 1/15", state, count);
        end
      end
    end
    n_cmp++;
    if (state !== 2'd3 || count !== 5'd16 || overflow !== 1'b0) begin
      n_err++; $display("FAIL fill_full: state=%0d count=%0d ovf=%0b, required 3/16/0", state, count, overflow);
    end
    retire(32'h140, 2'b00, 0);
    n_cmp++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_err++; $display("FAIL fill_drop: ovf=%0b count=%0d, required 1/16", overflow, count);
    end
    drain("fill");
  endtask
  task automatic test_wrap();
    do_arm(2'd1, 32'h0, 5'd0);
    for (int i = 0; i < 20; i++) retire(32'h100 + 4 * i, 2'(i + 1), 1);
    n_cmp++;
    if (state !== 2'd1 || count !== 5'd16 || overflow !== 1'b1) begin
      n_err++; $display("FAIL wrap_full: state=%0d count=%0d ovf=%0b, required 1/16/1", state, count, overflow);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++;
    if (state !== 2'd3 || bus.rd_pc !== 32'h110) begin
      n_err++; $display("FAIL wrap_stop: state=%0d first pc=%h, required 3/00000110", state, bus.rd_pc);
    end
    drain("wrap");
  endtask
  task automatic test_trig();
    do_arm(2'd3, 32'h200, 5'd3);
    for (int i = 0; i < 10; i++) retire(32'h300 + 4 * i, 2'b00, 1);
    retire(32'h200, 2'b10, 1);
    n_cmp++;
    if (state !== 2'd2 || triggered !== 1'b1) begin
      n_err++; $display("FAIL trig_hit: state=%0d trg=%0b, required 2/1", state, triggered);
    end
    for (int i = 0; i < 5; i++) begin
      retire(32'h400 + 4 * i, 2'b01, i < 3);
      if (i == 1) begin
        n_cmp++;
        if (state !== 2'd2) begin
          n_err++; $display("FAIL trig_post2: state=%0d, required 2", state);
        end
      end
    end
    n_cmp++;
    if (state !== 2'd3 || count !== 5'd14 || triggered !== 1'b1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL trig_done: state=%0d count=%0d trg=%0b ovf=%0b, required 3/14/1/0", state, count, triggered, overflow);
    end
    drain("trig");
  endtask
  task automatic test_trig_post0();
    do_arm(2'd3, 32'h200, 5'd0);
    for (int i = 0; i < 3; i++) retire(32'h500 + 4 * i, 2'b00, 1);
    retire(32'h200, 2'b11, 1);
    n_cmp++;
    if (state !== 2'd3 || count !== 5'd4) begin
      n_err++; $display("FAIL trig_post0: state=%0d count=%0d, required 3/4", state, count);
    end
    retire(32'h600, 2'b00, 0);
    drain("post0");
  endtask
  task automatic test_trig_clamp();
    do_arm(2'd3, 32'h200, 5'd20);
    for (int i = 0; i < 5; i++) retire(32'h700 + 4 * i, 2'b00, 1);
    retire(32'h200, 2'b00, 1);
    for (int i = 0; i < 15; i++) retire(32'h800 + 4 * i, 2'(i), 1);
    n_cmp++;
    if (state !== 2'd3 || count !== 5'd16 || overflow !== 1'b1 || bus.rd_pc !== 32'h200) begin
      n_err++; $display("FAIL trig_clamp: state=%0d count=%0d ovf=%0b pc=%h, required 3/16/1/00000200", state, count, overflow, bus.rd_pc);
    end
    drain("clamp");
  endtask
  task automatic test_stop_coincident();
    do_arm(2'd1, 32'h0, 5'd0);
    retire(32'h900, 2'b00, 1);
    retire(32'h904, 2'b01, 1);
    stop = 1'b1;
    retire(32'h908, 2'b10, 1);
    stop = 1'b0;
    n_cmp++;
    if (state !== 2'd3 || count !== 5'd3) begin
      n_err++; $display("FAIL stop_coincident: state=%0d count=%0d, required 3/3", state, count);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    drain("stop");
  endtask
  task automatic test_arm_during_drain();
    do_arm(2'd2, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) retire(32'hA00 + 4 * i, 2'b00, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    bus.rd_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (count !== 5'd3 || bus.rd_pc !== 32'hA08) begin
      n_err++; $display("FAIL partial_drain: count=%0d pc=%h, required 3/00000a08", count, bus.rd_pc);
    end
    do_arm(2'd2, 32'h0, 5'd0);
    n_cmp++;
    if (count !== 5'd0 || bus.rd_valid !== 1'b0 || state !== 2'd1) begin
      n_err++; $display("FAIL arm_drain: count=%0d rv=%0b state=%0d, required 0/0/1", count, bus.rd_valid, state);
    end
    bus.rd_ready = 1'b0;
  endtask
  task automatic test_reset_post();
    do_arm(2'd3, 32'h200, 5'd5);
    for (int i = 0; i < 17; i++) retire(32'hB00 + 4 * i, 2'b00, 0);
    retire(32'h200, 2'b00, 0);
    n_cmp++;
    if (state !== 2'd2 || triggered !== 1'b1 || overflow !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_post: state=%0d trg=%0b ovf=%0b, required 2/1/1", state, triggered, overflow);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || count !== 5'd0 || triggered !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_post: state=%0d count=%0d trg=%0b ovf=%0b, required all 0", state, count, triggered, overflow);
    end
    bus.rd_ready = 1'b1;
    retire(32'hC00, 2'b00, 0);
    tick(); tick();
    n_cmp++;
    if (count !== 5'd0 || bus.rd_valid !== 1'b0 || state !== 2'd0) begin
      n_err++; $display("FAIL idle_ready: count=%0d rv=%0b state=%0d, required 0/0/0", count, bus.rd_valid, state);
    end
    bus.rd_ready = 1'b0;
  endtask
  initial begin
    bus.rvfi_valid = 1'b0; bus.rvfi_pc = '0; bus.rvfi_insn = '0;
    bus.rvfi_trap = 1'b0; bus.rvfi_intr = 1'b0; bus.rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_off();
    test_fill();
    test_wrap();
    test_trig();
    test_trig_post0();
    test_trig_clamp();
    test_stop_coincident();
    test_arm_during_drain();
    test_reset_post();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
